// File: rtl/instruction_decode_unit.sv
// Decode stage: IF/ID register, 32-entry register file with write-through bypass,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode_unit #(
    parameter int INSTR_W = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [INSTR_W-1:0] iFetchInstruction,
    input  logic               iValidInstruction,
    input  logic [INSTR_W-1:0] iIF_ID_PC,
    input  logic               iFlush,
    input  logic               iWbEn,
    input  logic [REG_AW-1:0]  iWbAddr,
    input  logic [INSTR_W-1:0] iWbData,
    input  logic               iID_EX_MemRd,
    input  logic [REG_AW-1:0]  iID_EX_Rt,
    output logic               oPCWr,
    output logic               oID_EX_Valid,
    output logic [INSTR_W-1:0] oID_EX_PC,
    output logic [5:0]         oID_EX_Opcode,
    output logic [5:0]         oID_EX_Funct,
    output logic [REG_AW-1:0]  oID_EX_Rs,
    output logic [REG_AW-1:0]  oID_EX_Rt,
    output logic [REG_AW-1:0]  oID_EX_Rd,
    output logic [INSTR_W-1:0] oID_EX_RsData,
    output logic [INSTR_W-1:0] oID_EX_RtData,
    output logic [INSTR_W-1:0] oID_EX_Imm
);

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] pc;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [INSTR_W-1:0] rs_data;
        logic [INSTR_W-1:0] rt_data;
        logic [INSTR_W-1:0] imm;
    } id_ex_t;

    logic               if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [INSTR_W-1:0] if_id_pc_q,    if_id_pc_d;
    id_ex_t             id_ex_q,       id_ex_d;
    logic [INSTR_W-1:0] rf_q [REG_NUM];

    logic [5:0]         dec_opcode;
    logic [5:0]         dec_funct;
    logic [REG_AW-1:0]  dec_rs, dec_rt, dec_rd;
    logic [15:0]        dec_imm16;
    logic [INSTR_W-1:0] rs_data, rt_data, imm_ext;
    logic               load_use;

    assign dec_opcode = if_id_instr_q[31:26];
    assign dec_rs     = if_id_instr_q[25:21];
    assign dec_rt     = if_id_instr_q[20:16];
    assign dec_rd     = if_id_instr_q[15:11];
    assign dec_funct  = if_id_instr_q[5:0];
    assign dec_imm16  = if_id_instr_q[15:0];

    // The load leaves EX on the next edge, so this is naturally a one-cycle stall.
    assign load_use = iID_EX_MemRd && (iID_EX_Rt != '0) && if_id_valid_q &&
                      ((iID_EX_Rt == dec_rs) || (iID_EX_Rt == dec_rt));
    assign oPCWr    = load_use && !iFlush;

    // Register reads see a same-cycle writeback so no extra forwarding is needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        rs_data = '0;
        rt_data = '0;
        if (dec_rs != '0) begin
            rs_data = (iWbEn && iWbAddr == dec_rs) ? iWbData : rf_q[dec_rs];
        end
        if (dec_rt != '0) begin
            rt_data = (iWbEn && iWbAddr == dec_rt) ? iWbData : rf_q[dec_rt];
        end
    end

    always_comb begin
        if (dec_opcode == OP_ANDI || dec_opcode == OP_ORI || dec_opcode == OP_XORI) begin
            imm_ext = {{(INSTR_W-16){1'b0}}, dec_imm16};
        end else begin
            imm_ext = {{(INSTR_W-16){dec_imm16[15]}}, dec_imm16};
        end
    end

    always_comb begin
        if_id_valid_d = iValidInstruction;
        if_id_instr_d = iFetchInstruction;
        if_id_pc_d    = iIF_ID_PC;
        if (iFlush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = '0;
            if_id_pc_d    = '0;
        end else if (load_use) begin
            if_id_valid_d = if_id_valid_q;
            if_id_instr_d = if_id_instr_q;
            if_id_pc_d    = if_id_pc_q;
        end
    end

    always_comb begin
        id_ex_d = '0;
        if (!iFlush && !load_use) begin
            id_ex_d.valid   = if_id_valid_q;
            id_ex_d.pc      = if_id_pc_q;
            id_ex_d.opcode  = dec_opcode;
            id_ex_d.funct   = dec_funct;
            id_ex_d.rs      = dec_rs;
            id_ex_d.rt      = dec_rt;
            id_ex_d.rd      = dec_rd;
            id_ex_d.rs_data = rs_data;
            id_ex_d.rt_data = rt_data;
            id_ex_d.imm     = imm_ext;
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            id_ex_q       <= '0;
        end else begin
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            id_ex_q       <= id_ex_d;
        end
    end

    // NOTE: the register file is architecturally cleared on reset, so it is built
    // from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else if (iWbEn && iWbAddr != '0) begin
            rf_q[iWbAddr] <= iWbData;
        end
    end

    assign oID_EX_Valid  = id_ex_q.valid;
    assign oID_EX_PC     = id_ex_q.pc;
    assign oID_EX_Opcode = id_ex_q.opcode;
    assign oID_EX_Funct  = id_ex_q.funct;
    assign oID_EX_Rs     = id_ex_q.rs;
    assign oID_EX_Rt     = id_ex_q.rt;
    assign oID_EX_Rd     = id_ex_q.rd;
    assign oID_EX_RsData = id_ex_q.rs_data;
    assign oID_EX_RtData = id_ex_q.rt_data;
    assign oID_EX_Imm    = id_ex_q.imm;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Bench for instruction_decode_unit: directed scenarios plus random stimulus
// compared against a cycle-level reference model of the decode stage.
module tb_instruction_decode_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] iFetchInstruction;
    logic        iValidInstruction;
    logic [31:0] iIF_ID_PC;
    logic        iFlush;
    logic        iWbEn;
    logic [4:0]  iWbAddr;
    logic [31:0] iWbData;
    logic        iID_EX_MemRd;
    logic [4:0]  iID_EX_Rt;
    logic        oPCWr;
    logic        oID_EX_Valid;
    logic [31:0] oID_EX_PC;
    logic [5:0]  oID_EX_Opcode;
    logic [5:0]  oID_EX_Funct;
    logic [4:0]  oID_EX_Rs;
    logic [4:0]  oID_EX_Rt;
    logic [4:0]  oID_EX_Rd;
    logic [31:0] oID_EX_RsData;
    logic [31:0] oID_EX_RtData;
    logic [31:0] oID_EX_Imm;

    instruction_decode_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .iFetchInstruction (iFetchInstruction),
        .iValidInstruction (iValidInstruction),
        .iIF_ID_PC         (iIF_ID_PC),
        .iFlush            (iFlush),
        .iWbEn             (iWbEn),
        .iWbAddr           (iWbAddr),
        .iWbData           (iWbData),
        .iID_EX_MemRd      (iID_EX_MemRd),
        .iID_EX_Rt         (iID_EX_Rt),
        .oPCWr             (oPCWr),
        .oID_EX_Valid      (oID_EX_Valid),
        .oID_EX_PC         (oID_EX_PC),
        .oID_EX_Opcode     (oID_EX_Opcode),
        .oID_EX_Funct      (oID_EX_Funct),
        .oID_EX_Rs         (oID_EX_Rs),
        .oID_EX_Rt         (oID_EX_Rt),
        .oID_EX_Rd         (oID_EX_Rd),
        .oID_EX_RsData     (oID_EX_RsData),
        .oID_EX_RtData     (oID_EX_RtData),
        .oID_EX_Imm        (oID_EX_Imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: architectural registers, the instruction waiting
    // in decode, and what the execute stage should see next.
    logic [31:0] m_regs [32];
    logic        m_if_valid;
    logic [31:0] m_if_instr;
    logic [31:0] m_if_pc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_rs_data;
    logic [31:0] e_rt_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:11] = 5'(rd);
        w[5:0]   = 6'(fn);
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w[31:26] = 6'(op);
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:0]  = 16'(imm);
        return w;
    endfunction

    // andi/ori/xori treat the immediate as unsigned, everything else as signed.
    function automatic logic [31:0] m_imm(input logic [31:0] instr);
        int op;
        op = int'(instr[31:26]);
        if (op == 12 || op == 13 || op == 14) return 32'(int'(instr[15:0]));
        return 32'($signed(instr[15:0]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (iWbEn && iWbAddr == idx) return iWbData;
        return m_regs[idx];
    endfunction

    function automatic logic m_stall();
        logic [4:0] rs, rt;
        rs = m_if_instr[25:21];
        rt = m_if_instr[20:16];
        return iID_EX_MemRd && iID_EX_Rt != 5'd0 && m_if_valid &&
               (iID_EX_Rt == rs || iID_EX_Rt == rt);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_if_valid = 1'b0; m_if_instr = 32'h0; m_if_pc = 32'h0;
        e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0; e_rs_data = 32'h0; e_rt_data = 32'h0;
    endtask

    task automatic model_edge();
        logic stall;
        stall = m_stall();
        if (iFlush || stall) begin
            e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0; e_rs_data = 32'h0; e_rt_data = 32'h0;
        end else begin
            e_valid   = m_if_valid;
            e_pc      = m_if_pc;
            e_instr   = m_if_instr;
            e_rs_data = m_read(m_if_instr[25:21]);
            e_rt_data = m_read(m_if_instr[20:16]);
        end
        if (iWbEn && iWbAddr != 5'd0) m_regs[iWbAddr] = iWbData;
        if (iFlush) begin
            m_if_valid = 1'b0; m_if_instr = 32'h0; m_if_pc = 32'h0;
        end else if (!stall) begin
            m_if_valid = iValidInstruction; m_if_instr = iFetchInstruction; m_if_pc = iIF_ID_PC;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] imm_exp;
        imm_exp = e_valid ? m_imm(e_instr) : 32'h0;
        if (!e_valid && e_instr == 32'h0) imm_exp = 32'h0;
        check({tag, ".valid"},  32'(oID_EX_Valid),  32'(e_valid));
        check({tag, ".pc"},     oID_EX_PC,          e_pc);
        check({tag, ".opcode"}, 32'(oID_EX_Opcode), 32'(e_instr[31:26]));
        check({tag, ".funct"},  32'(oID_EX_Funct),  32'(e_instr[5:0]));
        check({tag, ".rs"},     32'(oID_EX_Rs),     32'(e_instr[25:21]));
        check({tag, ".rt"},     32'(oID_EX_Rt),     32'(e_instr[20:16]));
        check({tag, ".rd"},     32'(oID_EX_Rd),     32'(e_instr[15:11]));
        check({tag, ".rsdata"}, oID_EX_RsData,      e_rs_data);
        check({tag, ".rtdata"}, oID_EX_RtData,      e_rt_data);
        check({tag, ".imm"},    oID_EX_Imm,         m_imm(e_instr));
    endtask

    // Entered one time unit after a rising edge with inputs already driven;
    // returns one time unit after the next rising edge.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".pcwr"}, 32'(oPCWr), 32'(m_stall() && !iFlush));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        iFetchInstruction = 32'h0; iValidInstruction = 1'b0; iIF_ID_PC = 32'h0;
        iFlush = 1'b0; iWbEn = 1'b0; iWbAddr = 5'd0; iWbData = 32'h0;
        iID_EX_MemRd = 1'b0; iID_EX_Rt = 5'd0;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        iFetchInstruction = instr; iValidInstruction = 1'b1; iIF_ID_PC = pc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pcwr"},   32'(oPCWr),         32'h0);
        check({tag, ".valid"},  32'(oID_EX_Valid),  32'h0);
        check({tag, ".pc"},     oID_EX_PC,          32'h0);
        check({tag, ".opcode"}, 32'(oID_EX_Opcode), 32'h0);
        check({tag, ".funct"},  32'(oID_EX_Funct),  32'h0);
        check({tag, ".regs"},   32'({oID_EX_Rs, oID_EX_Rt, oID_EX_Rd}), 32'h0);
        check({tag, ".rsdata"}, oID_EX_RsData,      32'h0);
        check({tag, ".rtdata"}, oID_EX_RtData,      32'h0);
        check({tag, ".imm"},    oID_EX_Imm,         32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        model_reset();
        resetn = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Straight-line: ori then addi with a negative immediate.
        fetch(enc_i(6'h0D, 0, 1, 16'h8001), 32'h10);
        cycle("ori_fetch");
        fetch(enc_i(6'h08, 0, 2, 16'hFFFF), 32'h14);
        cycle("ori_dec");
        check("ori.imm",   oID_EX_Imm, 32'h0000_8001);
        check("ori.pc",    oID_EX_PC,  32'h10);
        check("ori.valid", 32'(oID_EX_Valid), 32'h1);
        idle_inputs();
        cycle("addi_dec");
        check("addi.imm",  oID_EX_Imm, 32'hFFFF_FFFF);
        check("addi.pc",   oID_EX_PC,  32'h14);

        // Bypass: writeback to r3 lands in the same cycle r3 is decoded.
        fetch(enc_r(3, 0, 7, 6'h20), 32'h20);
        cycle("byp_fetch");
        idle_inputs();
        fetch(enc_r(0, 3, 8, 6'h20), 32'h24);
        iWbEn = 1'b1; iWbAddr = 5'd3; iWbData = 32'hDEAD_BEEF;
        cycle("byp_dec");
        check("byp.rsdata", oID_EX_RsData, 32'hDEAD_BEEF);
        idle_inputs();
        iWbEn = 1'b1; iWbAddr = 5'd0; iWbData = 32'h1234_5678;
        cycle("r0_dec");
        check("r3.stored", oID_EX_RtData, 32'hDEAD_BEEF);
        fetch(enc_r(0, 0, 9, 6'h20), 32'h28);
        cycle("r0_fetch");
        idle_inputs();
        cycle("r0_read");
        check("r0.zero", oID_EX_RsData, 32'h0);

        // Load-use on r4: one stall cycle then the same add issues.
        fetch(enc_r(4, 6, 5, 6'h20), 32'h40);
        cycle("lu_fetch");
        fetch(enc_r(1, 1, 1, 6'h20), 32'h44);
        iID_EX_MemRd = 1'b1; iID_EX_Rt = 5'd4;
        #1;
        check("lu.pcwr_hi", 32'(oPCWr), 32'h1);
        cycle("lu_stall");
        check("lu.bubble", 32'(oID_EX_Valid), 32'h0);
        iID_EX_MemRd = 1'b0; iID_EX_Rt = 5'd0;
        #1;
        check("lu.pcwr_lo", 32'(oPCWr), 32'h0);
        cycle("lu_issue");
        check("lu.valid", 32'(oID_EX_Valid), 32'h1);
        check("lu.pc",    oID_EX_PC, 32'h40);
        check("lu.rd",    32'(oID_EX_Rd), 32'h5);

        // Load into r0 never stalls.
        fetch(enc_r(4, 0, 5, 6'h20), 32'h50);
        cycle("lu0_fetch");
        idle_inputs();
        iID_EX_MemRd = 1'b1; iID_EX_Rt = 5'd0;
        #1;
        check("lu0.pcwr", 32'(oPCWr), 32'h0);
        cycle("lu0_issue");
        check("lu0.valid", 32'(oID_EX_Valid), 32'h1);
        check("lu0.pc",    oID_EX_PC, 32'h50);

        // Flush coinciding with a load-use hazard.
        idle_inputs();
        fetch(enc_r(4, 6, 5, 6'h20), 32'h60);
        cycle("fh_fetch");
        fetch(enc_r(1, 2, 3, 6'h20), 32'h64);
        iID_EX_MemRd = 1'b1; iID_EX_Rt = 5'd4; iFlush = 1'b1;
        #1;
        check("fh.pcwr", 32'(oPCWr), 32'h0);
        cycle("fh_flush");
        check("fh.idex_valid", 32'(oID_EX_Valid), 32'h0);
        idle_inputs();
        cycle("fh_after");
        check("fh.ifid_valid", 32'(oID_EX_Valid), 32'h0);

        // Asynchronous reset mid-stream with a pending hazard.
        iWbEn = 1'b1; iWbAddr = 5'd5; iWbData = 32'hCAFE_0005;
        fetch(enc_r(5, 5, 2, 6'h20), 32'h70);
        cycle("rst_fill");
        idle_inputs();
        fetch(enc_r(1, 1, 1, 6'h20), 32'h74);
        cycle("rst_fill2");
        check("rst.pre_rsdata", oID_EX_RsData, 32'hCAFE_0005);
        iID_EX_MemRd = 1'b1; iID_EX_Rt = 5'd1;
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        #1;
        resetn = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        fetch(enc_r(5, 0, 2, 6'h20), 32'h80);
        cycle("rst_r5_fetch");
        idle_inputs();
        cycle("rst_r5_read");
        check("rst.r5", oID_EX_RsData, 32'h0);

        // Random traffic on a small register window to provoke hazards and bypasses.
        for (int n = 0; n < 400; n++) begin
            int pick;
            logic [31:0] instr;
            pick  = int'($urandom_range(0, 5));
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            case (pick)
                0: instr[31:26] = 6'h00;
                1: instr[31:26] = 6'h0C;
                2: instr[31:26] = 6'h0D;
                3: instr[31:26] = 6'h0E;
                4: instr[31:26] = 6'h23;
                default: ;
            endcase
            iFetchInstruction = instr;
            iValidInstruction = ($urandom_range(0, 9) < 8);
            iIF_ID_PC         = {$urandom, 2'b00};
            iFlush            = ($urandom_range(0, 9) == 0);
            iWbEn             = $urandom_range(0, 1) == 1;
            iWbAddr           = 5'($urandom_range(0, 7));
            iWbData           = $urandom;
            iID_EX_MemRd      = ($urandom_range(0, 9) < 3);
            iID_EX_Rt         = 5'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
